// File: rtl/dsp_alu_unit_pkg.sv
// Shared encodings for the RV32I execute-stage ALU: opcodes, ALU op codes and branch compare codes.
package dsp_alu_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        OP_AND   = 4'h0,
        OP_OR    = 4'h1,
        OP_ADD   = 4'h2,
        OP_SUB   = 4'h3,
        OP_SLT   = 4'h4,
        OP_SRL   = 4'h5,
        OP_SRA   = 4'h6,
        OP_SLL   = 4'h7,
        OP_XOR   = 4'h8,
        OP_SLTU  = 4'h9,
        OP_PASSB = 4'hA,
        OP_NONE  = 4'hF
    } alu_op_e;

    typedef enum logic [2:0] {
        CMP_NONE = 3'd0,
        CMP_BEQ  = 3'd1,
        CMP_BNE  = 3'd2,
        CMP_BLT  = 3'd3,
        CMP_BGE  = 3'd4,
        CMP_BLTU = 3'd5,
        CMP_BGEU = 3'd6,
        CMP_RSVD = 3'd7
    } cmp_e;

    // Shared R/I funct3 table; alt selects SUB/SRA.
    function automatic alu_op_e alu_f3_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? OP_SUB : OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return alt ? OP_SRA : OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

endpackage

// File: rtl/dsp_alu_unit_alu_control_decode.sv
// Combinational decode of {instr[30],funct3} and opcode into the 7-bit ALU control word {cmp, op}.
module alu_control_decode
    import dsp_alu_unit_pkg::*;
(
    input  logic [3:0] FuncCode,
    input  logic [6:0] Opcode,
    output logic [6:0] ALUCtl
);

    alu_op_e    w_op;
    cmp_e       w_cmp;
    logic [2:0] w_f3;

    assign w_f3 = FuncCode[2:0];

    always_comb begin
        w_op  = OP_NONE;
        w_cmp = CMP_NONE;
        case (Opcode)
            OPC_R:   w_op = alu_f3_op(w_f3, FuncCode[3]);
            // ADDI has no subtract form; instr[30] only matters for SRAI
            OPC_I:   w_op = alu_f3_op(w_f3, FuncCode[3] && (w_f3 != 3'b000));
            OPC_LOAD, OPC_STORE, OPC_AUIPC, OPC_JAL, OPC_JALR:
                     w_op = OP_ADD;
            OPC_LUI: w_op = OP_PASSB;
            OPC_BRANCH: begin
                w_op = OP_SUB;
                case (w_f3)
                    3'b000:  w_cmp = CMP_BEQ;
                    3'b001:  w_cmp = CMP_BNE;
                    3'b100:  w_cmp = CMP_BLT;
                    3'b101:  w_cmp = CMP_BGE;
                    3'b110:  w_cmp = CMP_BLTU;
                    3'b111:  w_cmp = CMP_BGEU;
                    default: w_cmp = CMP_NONE;
                endcase
            end
            default: ;
        endcase
    end

    assign ALUCtl = {w_cmp, w_op};

endmodule

// File: rtl/dsp_alu_unit.sv
// RV32I execute-stage ALU: decode, combinational datapath and branch compare, then one output register.
module dsp_alu_unit
    import dsp_alu_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  FuncCode,
    input  logic [6:0]  Opcode,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] ALUOut,
    output logic        Branch_Enable,
    output logic [6:0]  ALUCtl
);

    logic [6:0]  w_alu_ctl;
    logic [4:0]  w_shamt;
    logic [31:0] w_result;
    logic        w_taken;
    logic [31:0] r_alu_out;
    logic        r_branch;

    alu_control_decode u_decode (
        .FuncCode (FuncCode),
        .Opcode   (Opcode),
        .ALUCtl   (w_alu_ctl)
    );

    assign ALUCtl  = w_alu_ctl;
    assign w_shamt = B[4:0];

    always_comb begin
        w_result = '0;
        case (alu_op_e'(w_alu_ctl[3:0]))
            OP_AND:   w_result = A & B;
            OP_OR:    w_result = A | B;
            OP_ADD:   w_result = A + B;
            OP_SUB:   w_result = A - B;
            OP_SLT:   w_result = {31'd0, $signed(A) < $signed(B)};
            OP_SRL:   w_result = A >> w_shamt;
            OP_SRA:   w_result = $unsigned($signed(A) >>> w_shamt);
            OP_SLL:   w_result = A << w_shamt;
            OP_XOR:   w_result = A ^ B;
            OP_SLTU:  w_result = {31'd0, A < B};
            OP_PASSB: w_result = B;
            default:  w_result = '0;
        endcase
    end

    // Compare is independent of the op field so branches still see A vs B directly.
    always_comb begin
        w_taken = 1'b0;
        case (cmp_e'(w_alu_ctl[6:4]))
            CMP_BEQ:  w_taken = (A == B);
            CMP_BNE:  w_taken = (A != B);
            CMP_BLT:  w_taken = ($signed(A) <  $signed(B));
            CMP_BGE:  w_taken = ($signed(A) >= $signed(B));
            CMP_BLTU: w_taken = (A <  B);
            CMP_BGEU: w_taken = (A >= B);
            default:  w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_out <= '0;
            r_branch  <= 1'b0;
        end else begin
            r_alu_out <= w_result;
            r_branch  <= w_taken;
        end
    end

    assign ALUOut        = r_alu_out;
    assign Branch_Enable = r_branch;

endmodule

// File: tb/tb_dsp_alu_unit.sv
// Self-checking bench for dsp_alu_unit: directed vectors, reset cases and random stimulus vs a behavioural model.
module tb_dsp_alu_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  FuncCode = '0;
    logic [6:0]  Opcode = '0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] ALUOut;
    logic        Branch_Enable;
    logic [6:0]  ALUCtl;

    int checks = 0;
    int errors = 0;

    dsp_alu_unit dut (
        .clk           (clk),
        .rst           (rst),
        .FuncCode      (FuncCode),
        .Opcode        (Opcode),
        .A             (A),
        .B             (B),
        .ALUOut        (ALUOut),
        .Branch_Enable (Branch_Enable),
        .ALUCtl        (ALUCtl)
    );

    always #5 clk = ~clk;

    // Instruction-level reference: what an RV32I execute stage must produce.
    function automatic void model(input logic [6:0] opc, input logic [3:0] fc,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic br);
        logic [2:0] f3;
        int unsigned sh;
        f3  = fc[2:0];
        sh  = int'(b[4:0]);
        res = 32'd0;
        br  = 1'b0;
        if (opc == 7'b0110011 || opc == 7'b0010011) begin
            case (f3)
                3'd0: res = (opc == 7'b0110011 && fc[3]) ? a - b : a + b;
                3'd1: res = a << sh;
                3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: res = (a < b) ? 32'd1 : 32'd0;
                3'd4: res = a ^ b;
                3'd5: begin
                    res = a >> sh;
                    if (fc[3] && a[31]) res = res | ~(32'hFFFF_FFFF >> sh);
                end
                3'd6: res = a | b;
                default: res = a & b;
            endcase
        end else if (opc == 7'b0000011 || opc == 7'b0100011 || opc == 7'b0010111 ||
                     opc == 7'b1101111 || opc == 7'b1100111) begin
            res = a + b;
        end else if (opc == 7'b0110111) begin
            res = b;
        end else if (opc == 7'b1100011) begin
            res = a - b;
            case (f3)
                3'd0: br = (a == b);
                3'd1: br = (a != b);
                3'd4: br = ($signed(a) < $signed(b));
                3'd5: br = !($signed(a) < $signed(b));
                3'd6: br = (a < b);
                3'd7: br = !(a < b);
                default: br = 1'b0;
            endcase
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic op(input logic [6:0] opc, input logic [3:0] fc,
                      input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Opcode = opc; FuncCode = fc; A = a; B = b;
        @(posedge clk);
        #1;
    endtask

    task automatic dir(input string tag, input logic [6:0] opc, input logic [3:0] fc,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_br);
        op(opc, fc, a, b);
        chk({tag, "_out"}, ALUOut, exp_res);
        chk({tag, "_br"}, {31'd0, Branch_Enable}, {31'd0, exp_br});
    endtask

    logic [6:0] opc_list [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0010111,
                                  7'b1101111, 7'b1100111, 7'b0110111, 7'b1100011, 7'b0000000};

    initial begin
        logic [31:0] er;
        logic        eb;
        logic [6:0]  ro;
        logic [3:0]  rf;
        logic [31:0] ra, rb;

        #2;
        chk("reset_out", ALUOut, 32'd0);
        chk("reset_br", {31'd0, Branch_Enable}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        dir("and",     7'b0110011, 4'b0111, 32'h0F, 32'h55, 32'h05, 1'b0);
        dir("or",      7'b0110011, 4'b0110, 32'h0F, 32'h55, 32'h5F, 1'b0);
        dir("add",     7'b0110011, 4'b0000, 32'd10000, 32'd111, 32'd10111, 1'b0);
        dir("sub",     7'b0110011, 4'b1000, 32'd10000, 32'd111, 32'd9889, 1'b0);
        dir("addi",    7'b0010011, 4'b1000, 32'd10000, 32'd111, 32'd10111, 1'b0);
        dir("slt",     7'b0110011, 4'b0010, 32'd0, 32'd2, 32'd1, 1'b0);
        dir("srl",     7'b0110011, 4'b0101, 32'd16, 32'd2, 32'd4, 1'b0);
        dir("sra",     7'b0110011, 4'b1101, 32'd8, 32'd1, 32'd4, 1'b0);
        dir("sra31",   7'b0110011, 4'b1101, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0);
        dir("srai31",  7'b0010011, 4'b1101, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0);
        dir("sll",     7'b0110011, 4'b0001, 32'd2, 32'd2, 32'd8, 1'b0);
        dir("xor",     7'b0110011, 4'b0100, 32'h55, 32'hFF, 32'hAA, 1'b0);
        dir("sll0",    7'b0110011, 4'b0001, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF, 1'b0);
        dir("addwrap", 7'b0110011, 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        dir("sltmin",  7'b0110011, 4'b0010, 32'h8000_0000, 32'd1, 32'd1, 1'b0);
        dir("sltumin", 7'b0110011, 4'b0011, 32'h8000_0000, 32'd1, 32'd0, 1'b0);
        dir("beq",     7'b1100011, 4'b0000, 32'd5, 32'd5, 32'd0, 1'b1);
        dir("blt",     7'b1100011, 4'b0100, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b1);
        dir("bltu",    7'b1100011, 4'b0110, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0);
        dir("bf3_010", 7'b1100011, 4'b0010, 32'd5, 32'd5, 32'd0, 1'b0);
        dir("blt_eq",  7'b1100011, 4'b0100, 32'd7, 32'd7, 32'd0, 1'b0);
        dir("bltu_eq", 7'b1100011, 4'b0110, 32'd7, 32'd7, 32'd0, 1'b0);
        dir("bge_eq",  7'b1100011, 4'b0101, 32'd7, 32'd7, 32'd0, 1'b1);
        dir("bgeu_eq", 7'b1100011, 4'b0111, 32'd7, 32'd7, 32'd0, 1'b1);
        dir("lui",     7'b0110111, 4'b0000, 32'h1111_1111, 32'h1234_5000, 32'h1234_5000, 1'b0);
        dir("unknown", 7'b0000000, 4'b0000, 32'd3, 32'd4, 32'd0, 1'b0);

        // Decoded control word is combinational.
        @(negedge clk);
        Opcode = 7'b0110011; FuncCode = 4'b1000; #1;
        chk("ctl_sub", {25'd0, ALUCtl}, 32'h03);
        Opcode = 7'b1100011; FuncCode = 4'b0111; #1;
        chk("ctl_bgeu", {25'd0, ALUCtl}, 32'h63);
        Opcode = 7'b0110111; #1;
        chk("ctl_lui", {25'd0, ALUCtl}, 32'h0A);
        Opcode = 7'b1111111; #1;
        chk("ctl_unk", {25'd0, ALUCtl}, 32'h0F);

        // Mid-stream async reset between edges.
        dir("pre_rst", 7'b1100011, 4'b0000, 32'd9, 32'd9, 32'd0, 1'b1);
        op(7'b0110011, 4'b0000, 32'd40, 32'd2);
        chk("pre_rst_add", ALUOut, 32'd42);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out", ALUOut, 32'd0);
        @(posedge clk); #1;
        chk("held_rst_out", ALUOut, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dir("post_rst", 7'b0110011, 4'b0110, 32'hF0, 32'h0F, 32'hFF, 1'b0);

        for (int i = 0; i < 400; i++) begin
            ro = opc_list[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) ro = 7'($urandom);
            rf = 4'($urandom);
            case ($urandom_range(0, 3))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = $urandom; rb = ra; end
                2: begin ra = {$urandom_range(0, 1) == 1, 31'd0}; rb = 32'($urandom_range(0, 40)); end
                default: begin ra = $urandom; rb = 32'($urandom_range(0, 31)); end
            endcase
            op(ro, rf, ra, rb);
            model(ro, rf, ra, rb, er, eb);
            chk($sformatf("rnd%0d_out op=%b f=%b", i, ro, rf), ALUOut, er);
            chk($sformatf("rnd%0d_br op=%b f=%b", i, ro, rf), {31'd0, Branch_Enable}, {31'd0, eb});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
